// File: rtl/cgra_mem_pkg.sv
// Shared definitions for the CGRA memory subsystem: configuration header
// layout helpers, the broadcast target code and the loader state type.
package cgra_mem_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
  } cfg_state_e;

  // All-ones target code; slice down to the header target width.
  localparam logic [31:0] BROADCAST_TGT = '1;

  // Header layout, low to high: target, start address, word count.
  function automatic int hdr_tgt_lsb();
    return 0;
  endfunction

  function automatic int hdr_addr_lsb(input int tgt_w);
    return tgt_w;
  endfunction

  function automatic int hdr_cnt_lsb(input int tgt_w, input int addr_w);
    return tgt_w + addr_w;
  endfunction

  // The count carries one extra bit so a full-depth transfer is expressible.
  function automatic int hdr_cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int hdr_width(input int tgt_w, input int addr_w);
    return tgt_w + addr_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/cgra_cfg_loader.sv
// Streaming configuration loader: takes a header word (target, start
// address, count) followed by payload words and turns them into IM writes.
module cgra_cfg_loader
  import cgra_mem_pkg::*;
#(
  parameter int CFG_WIDTH     = 64,
  parameter int TGT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int PAYLOAD_WIDTH = 33,
  parameter int NUM_ID        = 9,
  parameter int NUM_IMM       = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CFG_WIDTH-1:0]         cfg_data,
  output logic                         cfg_busy,
  output logic                         cfg_done,
  output logic                         cfg_error,
  input  logic                         cfg_clear_error,
  output logic [NUM_ID+NUM_IMM-1:0]    im_we,
  output logic [ADDR_WIDTH-1:0]        im_waddr,
  output logic [PAYLOAD_WIDTH-1:0]     im_wdata
);

  localparam int NUM_IM    = NUM_ID + NUM_IMM;
  localparam int ADDR_LSB  = hdr_addr_lsb(TGT_WIDTH);
  localparam int CNT_LSB   = hdr_cnt_lsb(TGT_WIDTH, ADDR_WIDTH);
  localparam int CNT_WIDTH = hdr_cnt_width(ADDR_WIDTH);
  localparam logic [TGT_WIDTH-1:0] BCAST = BROADCAST_TGT[TGT_WIDTH-1:0];

  cfg_state_e             state_q, state_d;
  logic [TGT_WIDTH-1:0]   tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic [TGT_WIDTH-1:0]   hdr_tgt;
  logic [ADDR_WIDTH-1:0]  hdr_addr;
  logic [CNT_WIDTH-1:0]   hdr_cnt;
  logic                   hdr_tgt_ok;
  logic [NUM_IM-1:0]      tgt_sel;

  // Stream bits beyond the header and payload fields carry no meaning.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data;

  assign hdr_tgt    = cfg_data[TGT_WIDTH-1:0];
  assign hdr_addr   = cfg_data[ADDR_LSB +: ADDR_WIDTH];
  assign hdr_cnt    = cfg_data[CNT_LSB +: CNT_WIDTH];
  assign hdr_tgt_ok = (32'(hdr_tgt) < 32'(NUM_IM)) || (hdr_tgt == BCAST);

  assign cfg_ready = (state_q != S_DONE);
  assign cfg_busy  = (state_q == S_DATA);
  assign cfg_done  = (state_q == S_DONE);
  assign cfg_error = err_q;
  assign accept    = cfg_valid && cfg_ready;

  // Decode the latched target into a memory select; broadcast hits IDs only.
  always_comb begin
    tgt_sel = '0;
    for (int i = 0; i < NUM_IM; i++) begin
      tgt_sel[i] = (32'(tgt_q) == 32'(i)) || ((tgt_q == BCAST) && (i < NUM_ID));
    end
  end

  // FSM next state, counters, write strobes and error flag.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    im_we   = '0;
    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          tgt_d  = hdr_tgt;
          addr_d = hdr_addr;
          cnt_d  = hdr_cnt;
          if (!hdr_tgt_ok) begin
            err_d = 1'b1;
          end
          state_d = (hdr_cnt == '0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          im_we  = tgt_sel;
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_HDR;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
    // Clearing wins over a simultaneous set.
    if (cfg_clear_error) begin
      err_d = 1'b0;
    end
  end

  assign im_waddr = addr_q;
  assign im_wdata = cfg_data[PAYLOAD_WIDTH-1:0];

  // Loader state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      tgt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module ram_sdp #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Storage write port.
  // NOTE: the array is deliberately not reset; a reset loop over every word
  // would prevent mapping onto block RAM, and contents must survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Next read value: fetch when enabled, otherwise hold. Reading the array
  // before the edge gives old data on a same-address write.
  // NOTE: a combinational block assigns every output on every path (here via
  // the ternary) so no latch is inferred.
  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
  end

  // Read register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-byte write enables and a registered,
// read-first read port. Same-cycle bypass is handled by the parent.
module ram_sdp_be #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Next read value: fetch stored word when enabled, otherwise hold.
  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
  end

  // Read register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cgra_memory_cfg.sv
// CGRA memory subsystem: decoder and immediate instruction memories written
// by the streaming loader, plus byte-enabled local data memories with a
// same-cycle write-to-read bypass.
module cgra_memory_cfg
  import cgra_mem_pkg::*;
#(
  parameter int D_WIDTH           = 32,
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int NUM_ID            = 9,
  parameter int NUM_IMM           = 3,
  parameter int NUM_LOCAL_DMEM    = 1,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int LM_MEM_ADDR_WIDTH = 8,
  parameter int CFG_WIDTH         = 64,
  parameter int TGT_WIDTH         = 8
) (
  input  logic                                           iClk,
  input  logic                                           iReset,
  input  logic [NUM_LOCAL_DMEM*D_WIDTH/8-1:0]            iLM_WriteEnable,
  input  logic [NUM_LOCAL_DMEM-1:0]                      iLM_ReadEnable,
  input  logic [NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH-1:0]    iLM_WriteAddress,
  input  logic [NUM_LOCAL_DMEM*D_WIDTH-1:0]              iLM_WriteData,
  input  logic [NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH-1:0]    iLM_ReadAddress,
  output logic [NUM_LOCAL_DMEM*D_WIDTH-1:0]              oLM_ReadData,
  input  logic [NUM_ID+NUM_IMM-1:0]                      iIM_ReadEnable,
  input  logic [(NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH-1:0]  iIM_ReadAddress,
  output logic [NUM_ID*I_WIDTH+NUM_IMM*I_IMM_WIDTH-1:0]  oIM_ReadData,
  input  logic                                           iCfg_Valid,
  output logic                                           oCfg_Ready,
  input  logic [CFG_WIDTH-1:0]                           iCfg_Data,
  output logic                                           oCfg_Busy,
  output logic                                           oCfg_Done,
  output logic                                           oCfg_Error,
  input  logic                                           iCfg_ClearError
);

  localparam int NUM_IM = NUM_ID + NUM_IMM;
  localparam int IM_AW  = IM_MEM_ADDR_WIDTH;
  localparam int LM_AW  = LM_MEM_ADDR_WIDTH;
  localparam int NB     = D_WIDTH / 8;

  logic [NUM_IM-1:0]      im_we;
  logic [IM_AW-1:0]       im_waddr;
  logic [I_IMM_WIDTH-1:0] im_wdata;

  cgra_cfg_loader #(
    .CFG_WIDTH     (CFG_WIDTH),
    .TGT_WIDTH     (TGT_WIDTH),
    .ADDR_WIDTH    (IM_AW),
    .PAYLOAD_WIDTH (I_IMM_WIDTH),
    .NUM_ID        (NUM_ID),
    .NUM_IMM       (NUM_IMM)
  ) u_loader (
    .clk             (iClk),
    .rst             (iReset),
    .cfg_valid       (iCfg_Valid),
    .cfg_ready       (oCfg_Ready),
    .cfg_data        (iCfg_Data),
    .cfg_busy        (oCfg_Busy),
    .cfg_done        (oCfg_Done),
    .cfg_error       (oCfg_Error),
    .cfg_clear_error (iCfg_ClearError),
    .im_we           (im_we),
    .im_waddr        (im_waddr),
    .im_wdata        (im_wdata)
  );

  // Decoder instruction memories, read fields packed from bit 0 upward.
  for (genvar g = 0; g < NUM_ID; g++) begin : g_id
    ram_sdp #(.DW(I_WIDTH), .AW(IM_AW)) u_ram (
      .clk   (iClk),
      .rst   (iReset),
      .we    (im_we[g]),
      .waddr (im_waddr),
      .wdata (im_wdata[I_WIDTH-1:0]),
      .re    (iIM_ReadEnable[g]),
      .raddr (iIM_ReadAddress[g*IM_AW +: IM_AW]),
      .rdata (oIM_ReadData[g*I_WIDTH +: I_WIDTH])
    );
  end

  // Immediate instruction memories, packed above all decoder fields.
  for (genvar g = 0; g < NUM_IMM; g++) begin : g_imm
    ram_sdp #(.DW(I_IMM_WIDTH), .AW(IM_AW)) u_ram (
      .clk   (iClk),
      .rst   (iReset),
      .we    (im_we[NUM_ID+g]),
      .waddr (im_waddr),
      .wdata (im_wdata),
      .re    (iIM_ReadEnable[NUM_ID+g]),
      .raddr (iIM_ReadAddress[(NUM_ID+g)*IM_AW +: IM_AW]),
      .rdata (oIM_ReadData[NUM_ID*I_WIDTH + g*I_IMM_WIDTH +: I_IMM_WIDTH])
    );
  end

  // Local data memories. The RAM returns stored data; lanes being written to
  // the read address in the read cycle are replaced by the write data, using
  // a registered lane mask so the merge lines up with the registered read.
  for (genvar g = 0; g < NUM_LOCAL_DMEM; g++) begin : g_lm
    logic [NB-1:0]      lm_we;
    logic [LM_AW-1:0]   lm_waddr;
    logic [LM_AW-1:0]   lm_raddr;
    logic [D_WIDTH-1:0] lm_wdata;
    logic [D_WIDTH-1:0] lm_stored;
    logic [NB-1:0]      byp_q, byp_d;
    logic [D_WIDTH-1:0] fwd_q, fwd_d;
    logic [D_WIDTH-1:0] merged;

    assign lm_we    = iLM_WriteEnable[g*NB +: NB];
    assign lm_waddr = iLM_WriteAddress[g*LM_AW +: LM_AW];
    assign lm_raddr = iLM_ReadAddress[g*LM_AW +: LM_AW];
    assign lm_wdata = iLM_WriteData[g*D_WIDTH +: D_WIDTH];

    ram_sdp_be #(.DW(D_WIDTH), .AW(LM_AW)) u_ram (
      .clk   (iClk),
      .rst   (iReset),
      .we    (lm_we),
      .waddr (lm_waddr),
      .wdata (lm_wdata),
      .re    (iLM_ReadEnable[g]),
      .raddr (lm_raddr),
      .rdata (lm_stored)
    );

    // Capture bypass lanes and forwarded data alongside each enabled read.
    always_comb begin
      byp_d = byp_q;
      fwd_d = fwd_q;
      if (iLM_ReadEnable[g]) begin
        fwd_d = lm_wdata;
        for (int b = 0; b < NB; b++) begin
          byp_d[b] = lm_we[b] && (lm_waddr == lm_raddr);
        end
      end
    end

    // Bypass registers with synchronous reset.
    always_ff @(posedge iClk) begin
      if (iReset) begin
        byp_q <= '0;
        fwd_q <= '0;
      end else begin
        byp_q <= byp_d;
        fwd_q <= fwd_d;
      end
    end

    // Per-lane merge of forwarded and stored data.
    always_comb begin
      merged = lm_stored;
      for (int b = 0; b < NB; b++) begin
        if (byp_q[b]) begin
          merged[b*8 +: 8] = fwd_q[b*8 +: 8];
        end
      end
    end

    assign oLM_ReadData[g*D_WIDTH +: D_WIDTH] = merged;
  end

endmodule

// File: tb/tb_cgra_memory_cfg.sv
// Self-checking bench for cgra_memory_cfg with default parameters.
module tb_cgra_memory_cfg;

  localparam int D_WIDTH = 32;
  localparam int I_WIDTH = 12;
  localparam int I_IMM_WIDTH = 33;
  localparam int NUM_ID = 9;
  localparam int NUM_IMM = 3;
  localparam int NUM_IM = NUM_ID + NUM_IMM;
  localparam int NUM_LM = 1;
  localparam int IM_AW = 8;
  localparam int LM_AW = 8;
  localparam int CFG_WIDTH = 64;
  localparam int TGT_WIDTH = 8;
  localparam int NB = D_WIDTH / 8;

  logic                                      iClk;
  logic                                      iReset;
  logic [NUM_LM*NB-1:0]                      iLM_WriteEnable;
  logic [NUM_LM-1:0]                         iLM_ReadEnable;
  logic [NUM_LM*LM_AW-1:0]                   iLM_WriteAddress;
  logic [NUM_LM*D_WIDTH-1:0]                 iLM_WriteData;
  logic [NUM_LM*LM_AW-1:0]                   iLM_ReadAddress;
  logic [NUM_LM*D_WIDTH-1:0]                 oLM_ReadData;
  logic [NUM_IM-1:0]                         iIM_ReadEnable;
  logic [NUM_IM*IM_AW-1:0]                   iIM_ReadAddress;
  logic [NUM_ID*I_WIDTH+NUM_IMM*I_IMM_WIDTH-1:0] oIM_ReadData;
  logic                                      iCfg_Valid;
  logic                                      oCfg_Ready;
  logic [CFG_WIDTH-1:0]                      iCfg_Data;
  logic                                      oCfg_Busy;
  logic                                      oCfg_Done;
  logic                                      oCfg_Error;
  logic                                      iCfg_ClearError;

  cgra_memory_cfg #(
    .D_WIDTH(D_WIDTH), .I_WIDTH(I_WIDTH), .I_IMM_WIDTH(I_IMM_WIDTH),
    .NUM_ID(NUM_ID), .NUM_IMM(NUM_IMM), .NUM_LOCAL_DMEM(NUM_LM),
    .IM_MEM_ADDR_WIDTH(IM_AW), .LM_MEM_ADDR_WIDTH(LM_AW),
    .CFG_WIDTH(CFG_WIDTH), .TGT_WIDTH(TGT_WIDTH)
  ) dut (
    .iClk(iClk), .iReset(iReset),
    .iLM_WriteEnable(iLM_WriteEnable), .iLM_ReadEnable(iLM_ReadEnable),
    .iLM_WriteAddress(iLM_WriteAddress), .iLM_WriteData(iLM_WriteData),
    .iLM_ReadAddress(iLM_ReadAddress), .oLM_ReadData(oLM_ReadData),
    .iIM_ReadEnable(iIM_ReadEnable), .iIM_ReadAddress(iIM_ReadAddress),
    .oIM_ReadData(oIM_ReadData),
    .iCfg_Valid(iCfg_Valid), .oCfg_Ready(oCfg_Ready), .iCfg_Data(iCfg_Data),
    .oCfg_Busy(oCfg_Busy), .oCfg_Done(oCfg_Done), .oCfg_Error(oCfg_Error),
    .iCfg_ClearError(iCfg_ClearError)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // ---------------- reference model: contents per IM, known-written flags
  logic [32:0] m_mem   [NUM_IM][256];
  bit          m_known [NUM_IM][256];
  bit          m_err;

  function automatic bit tgt_valid(input int t);
    return (t < NUM_IM) || (t == 255);
  endfunction

  function automatic void m_write(input int t, input int a, input logic [63:0] d);
    bit hit;
    for (int i = 0; i < NUM_IM; i++) begin
      hit = (t == i) || ((t == 255) && (i < NUM_ID));
      if (hit) begin
        m_mem[i][a % 256]   = (i < NUM_ID) ? {21'b0, d[11:0]} : d[32:0];
        m_known[i][a % 256] = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] hdr(input int t, input int a, input int c);
    logic [63:0] h;
    h = '0;
    h[7:0]   = t[7:0];
    h[15:8]  = a[7:0];
    h[24:16] = c[8:0];
    return h;
  endfunction

  task automatic im_rd(input int idx, input int addr, output logic [32:0] v);
    iIM_ReadEnable = '0;
    iIM_ReadEnable[idx] = 1'b1;
    iIM_ReadAddress[idx*IM_AW +: IM_AW] = addr[7:0];
    step();
    iIM_ReadEnable = '0;
    if (idx < NUM_ID) v = {21'b0, oIM_ReadData[idx*I_WIDTH +: I_WIDTH]};
    else v = oIM_ReadData[NUM_ID*I_WIDTH + (idx-NUM_ID)*I_IMM_WIDTH +: I_IMM_WIDTH];
  endtask

  task automatic verify_im(input int idx, input int addr);
    logic [32:0] v;
    if (m_known[idx][addr % 256]) begin
      im_rd(idx, addr % 256, v);
      check($sformatf("im%0d[0x%02h]", idx, addr % 256), 64'(v), 64'(m_mem[idx][addr % 256]));
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !oCfg_Ready; i++) step();
    check("ready_before_hdr", 64'(oCfg_Ready), 64'd1);
  endtask

  // One complete transfer with continuous or randomly stalled valid.
  task automatic run_xfer(input int t, input int a, input int c, input logic [63:0] pay[$], input bit stall);
    int done_n, rdy_lo;
    done_n = 0;
    rdy_lo = 0;
    wait_ready();
    iCfg_Valid = 1'b1;
    iCfg_Data  = hdr(t, a, c);
    step();
    if (!tgt_valid(t)) m_err = 1'b1;
    check("busy_after_hdr", 64'(oCfg_Busy), 64'(c != 0));
    if (oCfg_Done) done_n++;
    if (!oCfg_Ready) rdy_lo++;
    for (int k = 0; k < c; k++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        iCfg_Valid = 1'b0;
        iCfg_Data  = {$urandom, $urandom};
        step();
        check("stall_busy", 64'(oCfg_Busy), 64'd1);
        if (oCfg_Done) done_n++;
        if (!oCfg_Ready) rdy_lo++;
      end
      iCfg_Valid = 1'b1;
      iCfg_Data  = pay[k];
      step();
      m_write(t, a + k, pay[k]);
      if (oCfg_Done) done_n++;
      if (!oCfg_Ready) rdy_lo++;
    end
    iCfg_Valid = 1'b0;
    repeat (3) begin
      step();
      if (oCfg_Done) done_n++;
      if (!oCfg_Ready) rdy_lo++;
    end
    check("done_pulses", 64'(done_n), 64'd1);
    check("ready_low_cycles", 64'(rdy_lo), 64'd1);
    check("error_flag", 64'(oCfg_Error), 64'(m_err));
  endtask

  typedef struct {
    logic [31:0] old_w;
    logic [3:0]  be;
    logic [31:0] new_w;
    logic [31:0] exp_r;
  } lm_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lm_vec_t     vecs[4];
    logic [63:0] pay[$];
    logic [32:0] v;
    int t, a, c, r;

    vecs[0] = '{32'h0123_4567, 4'b0000, 32'hFFFF_FFFF, 32'h0123_4567};
    vecs[1] = '{32'h0123_4567, 4'b1111, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[2] = '{32'hAAAA_5555, 4'b1010, 32'h1234_5678, 32'h12AA_5655};
    vecs[3] = '{32'h0000_0000, 4'b0011, 32'hCAFE_BABE, 32'h0000_BABE};

    iReset = 1'b1;
    iLM_WriteEnable = '0; iLM_ReadEnable = '0; iLM_WriteAddress = '0;
    iLM_WriteData = '0; iLM_ReadAddress = '0;
    iIM_ReadEnable = '0; iIM_ReadAddress = '0;
    iCfg_Valid = 1'b0; iCfg_Data = '0; iCfg_ClearError = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < NUM_IM; i++)
      for (int j = 0; j < 256; j++) m_known[i][j] = 1'b0;

    // ---------------- reset state
    step(); step();
    iReset = 1'b0;
    step();
    check("rst_ready", 64'(oCfg_Ready), 64'd1);
    check("rst_busy", 64'(oCfg_Busy), 64'd0);
    check("rst_done", 64'(oCfg_Done), 64'd0);
    check("rst_error", 64'(oCfg_Error), 64'd0);
    check("rst_lm_rdata", 64'(oLM_ReadData), 64'd0);
    check("rst_im_rdata_nonzero", 64'(oIM_ReadData != '0), 64'd0);

    // ---------------- single-target transfer to IM3
    pay.delete();
    for (int k = 0; k < 4; k++) pay.push_back(64'hA1 + 64'(k));
    run_xfer(3, 'h10, 4, pay, 1'b0);
    im_rd(3, 'h12, v);
    check("im3_0x12_latency", 64'(v), 64'hA3);
    for (int k = 0; k < 4; k++) verify_im(3, 'h10 + k);

    // ---------------- IMM target with address wrap, full 33-bit payload
    pay.delete();
    pay.push_back(64'h1_2345_6789);
    pay.push_back(64'h1_ABCD_EF01);
    pay.push_back(64'hFFFF_FFFE_8000_0001);
    run_xfer(NUM_ID, 'hFE, 3, pay, 1'b0);
    im_rd(NUM_ID, 'hFE, v);
    check("imm_0xfe_33bit", 64'(v), 64'h1_2345_6789);
    im_rd(NUM_ID, 'h00, v);
    check("imm_wrap_0x00", 64'(v), 64'h0_8000_0001);
    verify_im(NUM_ID, 'hFF);

    // ---------------- broadcast: IMM contents at the address must survive
    for (int i = NUM_ID; i < NUM_IM; i++) begin
      pay.delete();
      pay.push_back(64'h1_0000_0000 + 64'(i));
      run_xfer(i, 5, 1, pay, 1'b0);
    end
    pay.delete();
    pay.push_back(64'h5A5);
    run_xfer(255, 5, 1, pay, 1'b0);
    for (int i = 0; i < NUM_ID; i++) begin
      im_rd(i, 5, v);
      check($sformatf("bcast_id%0d", i), 64'(v), 64'h5A5);
    end
    for (int i = NUM_ID; i < NUM_IM; i++) verify_im(i, 5);

    // ---------------- invalid target: payload discarded, sticky error
    pay.delete();
    pay.push_back(64'h777);
    pay.push_back(64'h888);
    run_xfer('h20, 'h10, 2, pay, 1'b0);
    for (int i = 0; i < NUM_IM; i++) begin
      verify_im(i, 'h10);
      verify_im(i, 'h11);
    end
    // clear together with a new invalid header: clear wins
    iCfg_ClearError = 1'b1;
    iCfg_Valid = 1'b1;
    iCfg_Data = hdr('h30, 0, 0);
    step();
    iCfg_ClearError = 1'b0;
    iCfg_Valid = 1'b0;
    m_err = 1'b0;
    check("clear_beats_set", 64'(oCfg_Error), 64'd0);
    step();
    check("clear_beats_set_hold", 64'(oCfg_Error), 64'd0);

    // ---------------- IM read-first on same-cycle loader write
    pay.delete();
    pay.push_back(64'h111);
    run_xfer(4, 'h60, 1, pay, 1'b0);
    iCfg_Valid = 1'b1;
    iCfg_Data = hdr(4, 'h60, 1);
    step();
    iCfg_Data = 64'h222;
    iIM_ReadEnable[4] = 1'b1;
    iIM_ReadAddress[4*IM_AW +: IM_AW] = 8'h60;
    step();
    iCfg_Valid = 1'b0;
    iIM_ReadEnable = '0;
    m_write(4, 'h60, 64'h222);
    check("im_read_first", 64'(oIM_ReadData[4*I_WIDTH +: I_WIDTH]), 64'h111);
    step();
    verify_im(4, 'h60);

    // ---------------- LM byte-merged bypass
    iLM_WriteEnable = 4'hF; iLM_WriteAddress = 8'd7; iLM_WriteData = 32'hDEAD_BEEF;
    step();
    iLM_WriteEnable = 4'b0101; iLM_WriteData = 32'h1122_3344;
    iLM_ReadEnable = 1'b1; iLM_ReadAddress = 8'd7;
    step();
    iLM_WriteEnable = '0; iLM_ReadEnable = 1'b0;
    check("lm_bypass_merge", 64'(oLM_ReadData), 64'hDE22_BE44);
    step();
    check("lm_hold", 64'(oLM_ReadData), 64'hDE22_BE44);
    iLM_WriteEnable = 4'hF; iLM_WriteAddress = 8'd8; iLM_WriteData = 32'hFFFF_FFFF;
    iLM_ReadEnable = 1'b1; iLM_ReadAddress = 8'd7;
    step();
    iLM_WriteEnable = '0; iLM_ReadEnable = 1'b0;
    check("lm_other_addr_no_bypass", 64'(oLM_ReadData), 64'hDE22_BE44);

    for (int i = 0; i < 4; i++) begin
      iLM_WriteEnable = 4'hF; iLM_WriteAddress = 8'(32 + i); iLM_WriteData = vecs[i].old_w;
      step();
      iLM_WriteEnable = vecs[i].be; iLM_WriteData = vecs[i].new_w;
      iLM_ReadEnable = 1'b1; iLM_ReadAddress = 8'(32 + i);
      step();
      iLM_WriteEnable = '0;
      check($sformatf("lm_vec%0d_bypass", i), 64'(oLM_ReadData), 64'(vecs[i].exp_r));
      step();
      iLM_ReadEnable = 1'b0;
      check($sformatf("lm_vec%0d_stored", i), 64'(oLM_ReadData), 64'(vecs[i].exp_r));
    end

    // ---------------- reset in the middle of a payload
    wait_ready();
    iCfg_Valid = 1'b1;
    iCfg_Data = hdr(2, 'h40, 4);
    step();
    iCfg_Data = 64'hB1; step(); m_write(2, 'h40, 64'hB1);
    iCfg_Data = 64'hB2; step(); m_write(2, 'h41, 64'hB2);
    iCfg_Valid = 1'b0;
    iReset = 1'b1;
    step();
    iReset = 1'b0;
    check("midrst_busy", 64'(oCfg_Busy), 64'd0);
    check("midrst_ready", 64'(oCfg_Ready), 64'd1);
    pay.delete();
    pay.push_back(64'hC1);
    run_xfer(1, 'h50, 1, pay, 1'b0);
    verify_im(2, 'h40);
    verify_im(2, 'h41);
    verify_im(1, 'h50);

    // ---------------- randomized transfers with stalls
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 15);
      if (r < NUM_IM) t = r;
      else if (r < 14) t = 255;
      else t = $urandom_range(NUM_IM, 254);
      a = $urandom_range(0, 255);
      c = $urandom_range(0, 5);
      pay.delete();
      for (int k = 0; k < c; k++) pay.push_back({$urandom, $urandom});
      run_xfer(t, a, c, pay, 1'b1);
      for (int k = 0; k < c; k++) begin
        if (t == 255) begin
          for (int i = 0; i < NUM_ID; i++) verify_im(i, a + k);
        end else if (t < NUM_IM) begin
          verify_im(t, a + k);
        end
      end
      if (m_err) begin
        iCfg_ClearError = 1'b1;
        step();
        iCfg_ClearError = 1'b0;
        m_err = 1'b0;
        check("rand_clear_err", 64'(oCfg_Error), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_memory_cfg.md
Name: cgra_memory_cfg

Overview:
- Next-generation CGRA memory subsystem with fully parametrised counts: NUM_ID instruction-decoder IMs, NUM_IMM immediate IMs and NUM_LOCAL_DMEM byte-enabled local data memories, all generated by loop.
- Replaces the flat per-memory write-enable IM programming port with a streaming configuration loader (valid/ready, header plus payload), including broadcast mode.
- Adds same-cycle write-to-read bypass on local memories.
- Sits between the CGRA tile array (IM fetch, LM load/store) and the host/DMA configuration stream.

Parameters:
- D_WIDTH, 32, local-memory data width; byte lanes = D_WIDTH/8.
- I_WIDTH, 12, decoder instruction width.
- I_IMM_WIDTH, 33, immediate-unit instruction width.
- NUM_ID, 9, decoder instruction memories.
- NUM_IMM, 3, immediate instruction memories.
- NUM_LOCAL_DMEM, 1, local data memories.
- IM_MEM_ADDR_WIDTH, 8, IM depth is 2^IM_MEM_ADDR_WIDTH.
- LM_MEM_ADDR_WIDTH, 8, LM depth is 2^LM_MEM_ADDR_WIDTH.
- CFG_WIDTH, 64, config stream word width; must be >= I_IMM_WIDTH and >= header width.
- TGT_WIDTH, 8, header target-index field width.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iLM_WriteEnable  in  NUM_LOCAL_DMEM*D_WIDTH/8  per-memory byte write enables.
- iLM_ReadEnable  in  NUM_LOCAL_DMEM  read enables.
- iLM_WriteAddress  in  NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH  write addresses.
- iLM_WriteData  in  NUM_LOCAL_DMEM*D_WIDTH  write data.
- iLM_ReadAddress  in  NUM_LOCAL_DMEM*LM_MEM_ADDR_WIDTH  read addresses.
- oLM_ReadData  out  NUM_LOCAL_DMEM*D_WIDTH  registered read data.
- iIM_ReadEnable  in  NUM_ID+NUM_IMM  fetch enables; ID memories at indices 0..NUM_ID-1, IMM memories above.
- iIM_ReadAddress  in  (NUM_ID+NUM_IMM)*IM_MEM_ADDR_WIDTH  fetch addresses.
- oIM_ReadData  out  NUM_ID*I_WIDTH+NUM_IMM*I_IMM_WIDTH  ID fields packed low, IMM fields packed high.
- iCfg_Valid  in  1  config word valid.
- oCfg_Ready  out  1  loader accepts a word.
- iCfg_Data  in  CFG_WIDTH  header or payload word.
- oCfg_Busy  out  1  payload transfer in progress.
- oCfg_Done  out  1  one-cycle pulse at the end of each transfer.
- oCfg_Error  out  1  sticky: an invalid target was seen.
- iCfg_ClearError  in  1  clears oCfg_Error.

Behaviour:
- Reset values: all read-data registers 0; oCfg_Ready=1; oCfg_Busy=0; oCfg_Done=0; oCfg_Error=0; FSM in S_HDR. Memory contents are not cleared.
- Read latency is 1 cycle for both IMs and LMs. A read register updates only while its enable is high; otherwise it holds.
- A transfer is a word accepted on iCfg_Valid && oCfg_Ready.
- Header fields:
  - target = [TGT_WIDTH-1:0]
  - start address = next IM_MEM_ADDR_WIDTH bits
  - count = next IM_MEM_ADDR_WIDTH+1 bits
- FSM S_HDR:
  - Ready=1. On header accept, latch target, address and count.
  - count==0 goes to S_DONE with no writes.
  - Otherwise go to S_DATA; Busy=1.
- FSM S_DATA:
  - Ready=1. Each accepted word writes one word to the target at the current address (the IM write occurs in the accept cycle), then address+1 with wrap mod 2^IM_MEM_ADDR_WIDTH, and count-1.
  - Payload bits used: [I_WIDTH-1:0] for ID targets, [I_IMM_WIDTH-1:0] for IMM targets.
  - Acceptance of the last word goes to S_DONE.
- FSM S_DONE: Ready=0, Busy=0, Done=1 for exactly one cycle, then S_HDR.
- Target decode:
  - 0..NUM_ID+NUM_IMM-1 selects a single IM.
  - All-ones (BROADCAST) writes the same word to every ID memory; IMM memories are untouched.
  - Any other value: payload is consumed and discarded, oCfg_Error set in the header-accept cycle.
- oCfg_Error: iCfg_ClearError has priority over a simultaneous set.
- iCfg_Valid low in S_DATA stalls the transfer with no write and no state change.
- IM read and loader write to the same memory and address in the same cycle: read returns old data (read-first).
- LM read and write to the same memory and address in the same cycle, with read enabled: read data is merged per byte. Written lanes return new data; unwritten lanes return stored data.
- Reset mid-transfer: FSM returns to S_HDR; words already written remain; the remaining payload stream must be restarted by the host.

Decomposition:
- Package cgra_mem_pkg holds:
  - header field offset/width functions of TGT_WIDTH and IM_MEM_ADDR_WIDTH
  - BROADCAST target constant (all ones)
  - loader state enum {S_HDR, S_DATA, S_DONE}
- Sub-module cgra_cfg_loader: FSM, counters, target decode and error flag. It outputs per-memory write enables, a write address and write data.
- Top-level cgra_memory_cfg generates the RAM_SDP and RAM_SDP_BE instances plus the LM bypass merge.

Test Plan:
- Reset, then header {target=3, addr=0x10, count=4} and payload 0xA1..0xA4 with continuous valid → IM3 holds 0xA1..0xA4 at 0x10..0x13; a read of 0x12 returns 0xA3 one cycle later; Done pulses once; Ready low for exactly that cycle.
- Header {target=NUM_ID (first IMM), addr=0xFE, count=3}, payload 0x1_2345_6789 etc. → writes land at 0xFE, 0xFF, 0x00 (wrap); the full 33 bits read back.
- Header {target=0xFF, addr=5, count=1}, payload 0x5A5 → all 9 ID IMs return 0x5A5 at address 5; IMM IMs unchanged.
- Header {target=0x20, count=2} → Error=1, both words consumed, no memory changes. ClearError and a new invalid header in the same cycle → Error stays 0.
- LM: write 0xDEADBEEF to addr 7; then write 0x11223344 with byte enables 4'b0101 while reading addr 7 → read returns 0xDE22BE44.
- Assert iReset after 2 of 4 payload words → Busy=0, Ready=1; the first 2 words are present in the IM; the next word is interpreted as a header.
